// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Segment vectors are active low, ordered a..g (a = MSB).
package ssd_pkg;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [6:0] SEG7_OFF = 7'h7F;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_e;

    // Hex nibble to active-low a..g pattern
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational nibble to seven-segment decoder (active low, a..g).
module ssd_hex_decode (
    input  logic [3:0] nib_i,
    output logic [6:0] seg7_c
);
    import ssd_pkg::*;

    assign seg7_c = hex_to_seg(nib_i);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit seven-segment scan controller with double-buffered loads,
// leading-zero blanking, per-digit enable/DP and anti-ghost blank gaps.
module ssd_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYCLES = 131072,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lzb_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    load_ack,
    output logic                    frame_done
);
    import ssd_pkg::*;

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(DWELL_CYCLES - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VAL_W-1:0]       disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]  disp_dp_q, disp_dp_d;
    logic [VAL_W-1:0]       pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]  pend_dp_q, pend_dp_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [7:0]             seg_q, seg_d;
    logic                   ack_q, ack_d;
    logic                   fdone_q, fdone_d;

    logic                   wrap_c;
    logic [3:0]             nib_c;
    logic                   dp_c;
    logic [NUM_DIGITS-1:0]  lz_c;
    logic                   lzb_blank_c;
    logic [6:0]             seg7_c;

    // Slot sequencing and frame-boundary buffer swap
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        wrap_c     = 1'b0;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;

        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_ON;
                    cnt_d   = '0;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        wrap_c = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase

        // A load landing exactly on the boundary bypasses the pending stage
        if (wrap_c) begin
            if (load) begin
                disp_val_d = value;
                disp_dp_d  = dp_in;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end else if (pend_vld_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
                pend_vld_d = 1'b0;
                ack_d      = 1'b1;
            end
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end

        fdone_d = wrap_c;
    end

    // Digit select and leading-zero mask from the display buffer
    always_comb begin
        logic zero_run;
        nib_c    = '0;
        dp_c     = 1'b0;
        lz_c     = '0;
        zero_run = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_c = disp_val_q[4*i +: 4];
                dp_c  = disp_dp_q[i];
            end
        end
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_val_q[4*i +: 4] == 4'h0);
            lz_c[i]  = zero_run;
        end
        lzb_blank_c = 1'b0;
        for (int i = 1; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i) && lz_c[i] && lzb_en) begin
                lzb_blank_c = 1'b1;
            end
        end
    end

    ssd_hex_decode u_decode (
        .nib_i  (nib_c),
        .seg7_c (seg7_c)
    );

    // Pin values for the next cycle, derived from the current state
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_q == S_ON) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                an_d[i] = !((idx_q == IDX_W'(i)) && digit_en[i]);
            end
            seg_d = {(lzb_blank_c ? SEG7_OFF : seg7_c), ~dp_c};
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= S_BLANK;
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            an_q       <= '1;
            seg_q      <= SEG_OFF;
            ack_q      <= 1'b0;
            fdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            ack_q      <= ack_d;
            fdone_q    <= fdone_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign load_ack   = ack_q;
    assign frame_done = fdone_q;

endmodule
